// File: rtl/bus_pkg.sv
// Shared types and constants for the bus master port and its serial helpers.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CTRL,
    WAIT_RDY,
    WR_DATA,
    RD_REQ,
    RD_DATA,
    DONE
  } state_t;

  typedef enum logic {
    Read_slave  = 1'b0,
    Write_slave = 1'b1
  } rw_t;

  typedef enum logic {
    non_burst    = 1'b0,
    burst_master = 1'b1
  } burst_t;

  localparam logic [2:0] START_SEQ = 3'b111;

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load shift register: MSB shifts out, i_sin enters at the LSB.
module serial_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_shift,
  input  logic         i_sin,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rstN)        r_q <= '0;
    else if (i_load)  r_q <= i_data;
    else if (i_shift) r_q <= {r_q[W-2:0], i_sin};
  end

  assign o_q = r_q;

endmodule

// File: rtl/bus_master_port.sv
// Master-side serial bus port: control frame, write/read data phases, one transaction at a time.
// Optional ready-wait timeout enabled by defining BUS_TIMEOUT_EN.
module bus_master_port
  import bus_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 8,
  parameter  int unsigned ADDR_WIDTH  = 12,
  parameter  int unsigned SLAVES      = 3,
  parameter  int unsigned LEN_W       = 8,
  parameter  int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned SID_W       = $clog2(SLAVES)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SID_W-1:0]      req_sid,
  input  logic                  req_write,
  input  logic                  req_burst,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_data_valid,
  output logic                  wr_data_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  done,
  output logic                  err,
  output logic                  control,
  output logic                  wD,
  output logic                  valid,
  output logic                  last,
  input  logic                  rD,
  input  logic                  ready
);

  localparam int unsigned FRAME_W = 3 + SID_W + 2 + ADDR_WIDTH;
  localparam int unsigned BCNT_W  = $clog2((FRAME_W > DATA_WIDTH) ? FRAME_W : DATA_WIDTH);
  localparam logic [BCNT_W-1:0] CTRL_LAST = BCNT_W'(FRAME_W - 1);
  localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_WIDTH - 1);
  localparam logic [LEN_W-1:0]  ONE_WORD  = LEN_W'(1);

  state_t                r_state;
  rw_t                   r_rw;
  logic [BCNT_W-1:0]     r_bitcnt;
  logic [LEN_W-1:0]      r_count;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_wr_data_ready;
  logic                  r_rd_data_valid;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic [FRAME_W-1:0]    w_frame;
  logic [LEN_W-1:0]      w_len_n;
  logic                  w_ctrl_load;
  logic                  w_wr_go;
  logic                  w_rd_go;
  logic [FRAME_W-1:0]    w_ctrl_q;
  logic [DATA_WIDTH-1:0] w_wd_q;
  logic [DATA_WIDTH-1:0] w_rd_q;
  logic                  w_unused_bits;

  assign w_frame     = {START_SEQ, req_sid, req_write, req_burst, req_addr};
  assign w_len_n     = (burst_t'(req_burst) == burst_master && req_len != '0) ? req_len : ONE_WORD;
  assign w_ctrl_load = (r_state == IDLE) && req_valid;
  assign w_wr_go     = (r_state == WAIT_RDY) && (r_rw == Write_slave) && ready && wr_data_valid;
  assign w_rd_go     = (r_state == WAIT_RDY) && (r_rw == Read_slave) && ready;

  // Shifters fill with zeros, so control and wD fall to 0 once their bits are out.
  serial_shift_reg #(.W(FRAME_W)) u_ctrl_sr (
    .clk     (clk),
    .rstN    (rstN),
    .i_load  (w_ctrl_load),
    .i_data  (w_frame),
    .i_shift (r_state == CTRL),
    .i_sin   (1'b0),
    .o_q     (w_ctrl_q)
  );

  serial_shift_reg #(.W(DATA_WIDTH)) u_wd_sr (
    .clk     (clk),
    .rstN    (rstN),
    .i_load  (w_wr_go),
    .i_data  (wr_data),
    .i_shift (r_state == WR_DATA),
    .i_sin   (1'b0),
    .o_q     (w_wd_q)
  );

  serial_shift_reg #(.W(DATA_WIDTH)) u_rd_sr (
    .clk     (clk),
    .rstN    (rstN),
    .i_load  (1'b0),
    .i_data  ('0),
    .i_shift (r_state == RD_DATA),
    .i_sin   (rD),
    .o_q     (w_rd_q)
  );

  assign w_unused_bits = ^{w_ctrl_q[FRAME_W-2:0], w_wd_q[DATA_WIDTH-2:0], w_rd_q[DATA_WIDTH-1]};

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_tocnt;
  logic            r_err;
  logic            w_timeout;

  assign w_timeout = (r_state == WAIT_RDY) && !w_wr_go && !w_rd_go && (r_tocnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_tocnt <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err   <= w_timeout;
      r_tocnt <= ((r_state == WAIT_RDY) && !w_wr_go && !w_rd_go && !w_timeout)
                 ? r_tocnt + TO_W'(1) : '0;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state         <= IDLE;
      r_rw            <= Read_slave;
      r_bitcnt        <= '0;
      r_count         <= '0;
      r_valid         <= 1'b0;
      r_last          <= 1'b0;
      r_wr_data_ready <= 1'b0;
      r_rd_data_valid <= 1'b0;
      r_done          <= 1'b0;
      r_rd_data       <= '0;
    end else begin
      r_wr_data_ready <= 1'b0;
      r_rd_data_valid <= 1'b0;
      r_done          <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_rw     <= rw_t'(req_write);
            r_count  <= w_len_n;
            r_bitcnt <= '0;
            r_state  <= CTRL;
          end
        end
        CTRL: begin
          if (r_bitcnt == CTRL_LAST) begin
            r_bitcnt <= '0;
            r_state  <= WAIT_RDY;
          end else begin
            r_bitcnt <= r_bitcnt + BCNT_W'(1);
          end
        end
        WAIT_RDY: begin
          if (w_wr_go) begin
            r_wr_data_ready <= 1'b1;
            r_valid         <= 1'b1;
            r_last          <= (r_count == ONE_WORD);
            r_bitcnt        <= '0;
            r_state         <= WR_DATA;
          end else if (w_rd_go) begin
            r_valid <= 1'b1;
            r_last  <= (r_count == ONE_WORD);
            r_state <= RD_REQ;
          end
`ifdef BUS_TIMEOUT_EN
          else if (w_timeout) begin
            r_state <= IDLE;
          end
`endif
        end
        WR_DATA: begin
          if (r_bitcnt == DATA_LAST) begin
            r_bitcnt <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_count  <= r_count - ONE_WORD;
            r_done   <= (r_count == ONE_WORD);
            r_state  <= (r_count == ONE_WORD) ? DONE : WAIT_RDY;
          end else begin
            r_bitcnt <= r_bitcnt + BCNT_W'(1);
          end
        end
        RD_REQ: begin
          r_valid  <= 1'b0;
          r_last   <= 1'b0;
          r_bitcnt <= '0;
          r_state  <= RD_DATA;
        end
        RD_DATA: begin
          if (r_bitcnt == DATA_LAST) begin
            // Final bit is captured straight from rD so rd_data is valid the very next cycle.
            r_rd_data       <= {w_rd_q[DATA_WIDTH-2:0], rD};
            r_rd_data_valid <= 1'b1;
            r_bitcnt        <= '0;
            r_count         <= r_count - ONE_WORD;
            r_done          <= (r_count == ONE_WORD);
            r_state         <= (r_count == ONE_WORD) ? DONE : WAIT_RDY;
          end else begin
            r_bitcnt <= r_bitcnt + BCNT_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready     = (r_state == IDLE);
  assign control       = w_ctrl_q[FRAME_W-1];
  assign wD            = w_wd_q[DATA_WIDTH-1];
  assign valid         = r_valid;
  assign last          = r_last;
  assign wr_data_ready = r_wr_data_ready;
  assign rd_data_valid = r_rd_data_valid;
  assign rd_data       = r_rd_data;
  assign done          = r_done;

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port: directed vector table, corner sequences, randomized transactions.
module tb_bus_master_port;

  logic        clk;
  logic        rstN;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_sid;
  logic        req_write;
  logic        req_burst;
  logic [11:0] req_addr;
  logic [7:0]  req_len;
  logic [7:0]  wr_data;
  logic        wr_data_valid;
  logic        wr_data_ready;
  logic [7:0]  rd_data;
  logic        rd_data_valid;
  logic        done;
  logic        err;
  logic        control;
  logic        wD;
  logic        valid;
  logic        last;
  logic        rD;
  logic        ready;

  int unsigned nvec;
  int unsigned nerr;

  bus_master_port #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (12),
    .SLAVES      (3),
    .LEN_W       (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk           (clk),
    .rstN          (rstN),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_sid       (req_sid),
    .req_write     (req_write),
    .req_burst     (req_burst),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .wr_data       (wr_data),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .done          (done),
    .err           (err),
    .control       (control),
    .wD            (wD),
    .valid         (valid),
    .last          (last),
    .rD            (rD),
    .ready         (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sid;
    logic        wr;
    logic        burst;
    logic [11:0] addr;
    logic [7:0]  len;
    logic [7:0]  d0;
    int unsigned stall;
    logic [18:0] exp_frame;
    int unsigned exp_n;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame layout and effective word count straight from the bus rules.
  function automatic logic [18:0] model_frame(input logic [1:0] sid, input logic wr,
                                              input logic b, input logic [11:0] addr);
    return {3'b111, sid, wr, b, addr};
  endfunction

  function automatic int unsigned model_n(input logic b, input logic [7:0] len);
    if (!b) return 1;
    return (len == 0) ? 1 : int'(len);
  endfunction

  task automatic run_txn(input vec_t v, input bit rnd);
    logic [18:0] fr;
    logic [7:0]  word;
    logic [7:0]  obs;
    int unsigned k, validc, lastc, pulses, gapbad;
    chk("req_ready_idle", req_ready, 1);
    req_sid   = v.sid;
    req_write = v.wr;
    req_burst = v.burst;
    req_addr  = v.addr;
    req_len   = v.len;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_ready_busy", req_ready, 0);
    fr = '0;
    for (int unsigned i = 0; i < 19; i++) begin
      fr = {fr[17:0], control};
      if (rnd) begin
        req_valid = 1'($urandom);
        req_addr  = 12'($urandom);
        req_sid   = 2'($urandom);
      end
      @(negedge clk);
    end
    chk("frame", fr, v.exp_frame);
    chk("control_idle", control, 0);
    for (int unsigned w = 0; w < v.exp_n; w++) begin
      word = (w == 0) ? v.d0 : 8'($urandom);
      k = (w == 1) ? v.stall : (rnd ? $urandom_range(0, 3) : 0);
      gapbad = 0;
      for (int unsigned s = 0; s < k; s++) begin
        gapbad += valid;
        if (v.wr && $urandom_range(0, 1) == 0) begin
          ready = 1'b1; wr_data_valid = 1'b0;
        end else begin
          ready = 1'b0; wr_data_valid = 1'($urandom);
        end
        @(negedge clk);
      end
      gapbad += valid;
      chk("wait_valid_low", gapbad, 0);
      ready         = 1'b1;
      wr_data_valid = v.wr;
      wr_data       = word;
      @(negedge clk);
      ready         = rnd ? 1'($urandom) : 1'b1;
      wr_data_valid = 1'b0;
      wr_data       = 8'($urandom);
      if (v.wr) begin
        obs = '0; validc = 0; lastc = 0; pulses = 0;
        chk("wr_data_ready_pulse", wr_data_ready, 1);
        for (int unsigned j = 0; j < 8; j++) begin
          obs = {obs[6:0], wD};
          validc += valid;
          lastc  += last;
          pulses += wr_data_ready;
          if (rnd) begin
            req_valid = 1'($urandom);
            ready     = 1'($urandom);
          end
          @(negedge clk);
        end
        chk("wdata", obs, word);
        chk("wr_valid_cycles", validc, 8);
        chk("wr_last_cycles", lastc, (w == v.exp_n - 1) ? 8 : 0);
        chk("wr_data_ready_count", pulses, 1);
        chk("valid_after_word", valid, 0);
      end else begin
        chk("rd_req_valid", valid, 1);
        chk("rd_req_last", last, (w == v.exp_n - 1) ? 1 : 0);
        validc = 0; pulses = 0;
        for (int unsigned j = 0; j < 8; j++) begin
          @(negedge clk);
          rD = word[7 - j];
          validc += valid;
          pulses += rd_data_valid;
          if (rnd) begin
            req_valid = 1'($urandom);
            ready     = 1'($urandom);
          end
        end
        @(negedge clk);
        rD = 1'($urandom);
        chk("rd_phase_valid_low", validc, 0);
        chk("rd_early_pulse", pulses, 0);
        chk("rd_data", rd_data, word);
        chk("rd_data_valid", rd_data_valid, 1);
      end
      req_valid = 1'b0;
      chk("done_flag", done, (w == v.exp_n - 1) ? 1 : 0);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("done_single", done, 0);
    chk("req_ready_end", req_ready, 1);
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    nvec = 0; nerr = 0;
    rstN = 1'b0; req_valid = 1'b0; req_sid = '0; req_write = 1'b0; req_burst = 1'b0;
    req_addr = '0; req_len = '0; wr_data = '0; wr_data_valid = 1'b0; rD = 1'b0; ready = 1'b1;

    //           sid    wr    b     addr     len    d0     stall frame                              n
    tbl[0] = '{2'd1, 1'b1, 1'b0, 12'h0A5, 8'd0, 8'hC3, 0, 19'b111_01_1_0_0000_1010_0101, 1};
    tbl[1] = '{2'd0, 1'b1, 1'b1, 12'h7FF, 8'd3, 8'h96, 5, 19'b111_00_1_1_0111_1111_1111, 3};
    tbl[2] = '{2'd2, 1'b0, 1'b1, 12'h003, 8'd1, 8'h5A, 0, 19'b111_10_0_1_0000_0000_0011, 1};
    tbl[3] = '{2'd1, 1'b1, 1'b1, 12'h800, 8'd0, 8'h3C, 0, 19'b111_01_1_1_1000_0000_0000, 1};
    tbl[4] = '{2'd0, 1'b0, 1'b1, 12'hFFF, 8'd0, 8'h81, 0, 19'b111_00_0_1_1111_1111_1111, 1};
    tbl[5] = '{2'd2, 1'b0, 1'b1, 12'hABC, 8'd4, 8'hE7, 2, 19'b111_10_0_1_1010_1011_1100, 4};
    tbl[6] = '{2'd1, 1'b0, 1'b0, 12'h456, 8'd9, 8'hA7, 0, 19'b111_01_0_0_0100_0101_0110, 1};

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_bus", {control, wD, valid, last}, 0);
    chk("rst_pulses", {wr_data_ready, rd_data_valid, done, err}, 0);
    chk("rst_rd_data", rd_data, 0);
    rstN = 1'b1;
    @(negedge clk);

    for (int unsigned i = 0; i < 7; i++) run_txn(tbl[i], 1'b0);

    // Reset in the middle of a write word.
    chk("pre_reset_rd_data", rd_data, 8'hA7);
    req_sid = 2'd1; req_write = 1'b1; req_burst = 1'b1; req_addr = 12'h321; req_len = 8'd2;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (19) @(negedge clk);
    ready = 1'b1; wr_data_valid = 1'b1; wr_data = 8'hFF;
    @(negedge clk);
    wr_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_word_valid", {valid, wD}, 2'b11);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    chk("midrst_bus", {control, wD, valid, last}, 0);
    chk("midrst_pulses", {wr_data_ready, rd_data_valid, done, err}, 0);
    chk("midrst_rd_data", rd_data, 0);
    chk("midrst_req_ready", req_ready, 1);
    @(negedge clk);
    chk("midrst_stays_idle", {req_ready, valid, control}, 3'b100);

    for (int unsigned i = 0; i < 40; i++) begin
      rv.sid   = 2'($urandom);
      rv.wr    = 1'($urandom);
      rv.burst = 1'($urandom);
      rv.addr  = 12'($urandom);
      rv.len   = 8'($urandom_range(0, 5));
      rv.d0    = 8'($urandom);
      rv.stall = $urandom_range(0, 5);
      rv.exp_frame = model_frame(rv.sid, rv.wr, rv.burst, rv.addr);
      rv.exp_n     = model_n(rv.burst, rv.len);
      run_txn(rv, 1'b1);
    end

    // Longest burst: count must not wrap.
    rv.sid = 2'd3; rv.wr = 1'b1; rv.burst = 1'b1; rv.addr = 12'h5A5; rv.len = 8'd255;
    rv.d0 = 8'h01; rv.stall = 1;
    rv.exp_frame = model_frame(rv.sid, rv.wr, rv.burst, rv.addr);
    rv.exp_n     = model_n(rv.burst, rv.len);
    run_txn(rv, 1'b0);

`ifdef BUS_TIMEOUT_EN
    begin
      int unsigned found, errc, donec;
      found = 0; errc = 0; donec = 0;
      req_sid = 2'd2; req_write = 1'b1; req_burst = 1'b0; req_addr = 12'h111; req_len = 8'd0;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (19) @(negedge clk);
      ready = 1'b0; wr_data_valid = 1'b0;
      for (int unsigned k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (err && found == 0) found = k;
        errc  += err;
        donec += done;
      end
      chk("timeout_cycle", found, 16);
      chk("timeout_err_count", errc, 1);
      chk("timeout_no_done", donec, 0);
      chk("timeout_idle", req_ready, 1);
      chk("timeout_bus", {control, wD, valid, last}, 0);
      ready = 1'b1;
      @(negedge clk);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
